// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Runs on master_clk and produces a
// one-cycle pixel clock-enable from an internal divider, so no derived clock
// is needed. Generates pixel coordinates, the display-area/blank flag, the
// programmable-polarity sync pulses, line/frame start strobes and a DAC clock.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   defined   -> pat_R/G/B carry 8 vertical colour bars inside the active area
//   undefined -> pat_R/G/B are tied to zero and no bar logic exists
//
// Ports:
//   master_clk    in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   run (1) / hold-and-clear (0)
//   pix_ce        out  pixel clock-enable, one master_clk cycle per pixel
//   DAC_clk       out  pixel-rate clock, high for the first ceil(CLK_DIV/2)
//                      cycles of each pixel
//   xPixel        out  horizontal count, 0 .. H_TOTAL-1
//   yPixel        out  vertical count, 0 .. V_TOTAL-1
//   display_area  out  current pixel lies in the visible region
//   blank_n       out  same as display_area
//   VGA_hSync     out  horizontal sync, active level H_POL
//   VGA_vSync     out  vertical sync, active level V_POL
//   line_start    out  one-cycle strobe when xPixel wraps to 0
//   frame_start   out  one-cycle strobe when (xPixel, yPixel) wraps to (0, 0)
//   pat_R/G/B     out  test-pattern colour channels
//
// Every output is a register loaded from the next-state coordinates, so all
// outputs describe the same pixel in the same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 11
) (
  input  logic          master_clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pix_ce,
  output logic          DAC_clk,
  output logic [CW-1:0] xPixel,
  output logic [CW-1:0] yPixel,
  output logic          display_area,
  output logic          blank_n,
  output logic          VGA_hSync,
  output logic          VGA_vSync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    pat_R,
  output logic [7:0]    pat_G,
  output logic [7:0]    pat_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DAC_HIGH = DIV_W'((CLK_DIV + 1) / 2);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Region bounds carry one extra bit so an end bound equal to the total
  // still compares correctly when the total is a power of two.
  localparam logic [CW:0] H_ACT_C  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_ACT_C  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_BEG_C = (CW+1)'(HS_BEG);
  localparam logic [CW:0] HS_END_C = (CW+1)'(HS_END);
  localparam logic [CW:0] VS_BEG_C = (CW+1)'(VS_BEG);
  localparam logic [CW:0] VS_END_C = (CW+1)'(VS_END);

  localparam logic H_ACT_LVL = (H_POL != 0);
  localparam logic V_ACT_LVL = (V_POL != 0);

  localparam bit CW_OK = (longint'(H_TOTAL - 1) < (longint'(1) << CW)) &&
                         (longint'(V_TOTAL - 1) < (longint'(1) << CW));

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic             adv, x_wrap, y_wrap;
  logic             hs_on, vs_on;
  logic             active_d, hsync_d, vsync_d, dac_d;
  logic             pix_ce_q, dac_q, disp_q, hsync_q, vsync_q, ls_q, fs_q;

  // Next-state: divider, coordinates and everything derived from them
  always_comb begin
    adv      = enable && (div_q == DIV_LAST);
    x_wrap   = adv && (x_q == H_LAST);
    y_wrap   = x_wrap && (y_q == V_LAST);
    div_d    = '0;
    x_d      = x_q;
    y_d      = y_q;

    if (!enable) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (!adv) div_d = div_q + DIV_W'(1);
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + CW'(1);
      end else if (adv) begin
        x_d = x_q + CW'(1);
      end
    end

    hs_on    = ({1'b0, x_d} >= HS_BEG_C) && ({1'b0, x_d} < HS_END_C);
    vs_on    = ({1'b0, y_d} >= VS_BEG_C) && ({1'b0, y_d} < VS_END_C);
    active_d = enable && ({1'b0, x_d} < H_ACT_C) && ({1'b0, y_d} < V_ACT_C);
    hsync_d  = (enable && hs_on) ? H_ACT_LVL : ~H_ACT_LVL;
    vsync_d  = (enable && vs_on) ? V_ACT_LVL : ~V_ACT_LVL;
    // The divider restarts at 0 on the cycle a new pixel appears, so its
    // next value is the position within the pixel the DAC clock follows.
    dac_d    = enable && (div_d < DAC_HIGH);
  end

  // Output register stage
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_ce_q <= 1'b0;
      dac_q    <= 1'b0;
      disp_q   <= 1'b0;
      hsync_q  <= ~H_ACT_LVL;
      vsync_q  <= ~V_ACT_LVL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_ce_q <= adv;
      dac_q    <= dac_d;
      disp_q   <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      ls_q     <= x_wrap;
      fs_q     <= y_wrap;
    end
  end

  assign pix_ce       = pix_ce_q;
  assign DAC_clk      = dac_q;
  assign xPixel       = x_q;
  assign yPixel       = y_q;
  assign display_area = disp_q;
  assign blank_n      = disp_q;
  assign VGA_hSync    = hsync_q;
  assign VGA_vSync    = vsync_q;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

  logic [CW-1:0] bar_idx;
  logic [2:0]    bar;
  logic [7:0]    pat_r_d, pat_g_d, pat_b_d;
  logic [7:0]    pat_r_q, pat_g_q, pat_b_q;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
  // directly onto the bits of the bar index: R = ~b1, G = ~b2, B = ~b0.
  always_comb begin
    bar_idx = x_d / CW'(BAR_W);
    bar     = (bar_idx > CW'(7)) ? 3'd7 : bar_idx[2:0];
    pat_r_d = active_d ? {8{~bar[1]}} : 8'h00;
    pat_g_d = active_d ? {8{~bar[2]}} : 8'h00;
    pat_b_d = active_d ? {8{~bar[0]}} : 8'h00;
  end

  // Pattern register stage, aligned with the coordinate registers
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r_q <= 8'h00;
      pat_g_q <= 8'h00;
      pat_b_q <= 8'h00;
    end else begin
      pat_r_q <= pat_r_d;
      pat_g_q <= pat_g_d;
      pat_b_q <= pat_b_d;
    end
  end

  assign pat_R = pat_r_q;
  assign pat_G = pat_g_q;
  assign pat_B = pat_b_q;
`else
  assign pat_R = 8'h00;
  assign pat_G = 8'h00;
  assign pat_B = 8'h00;
`endif

  // The coordinate counters must be wide enough for the largest count.
  cw_fits_a: assert property (@(posedge master_clk) CW_OK);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Runs on master_clk with an internal pixel clock-enable divider instead of a derived clock.
- Generates pixel coordinates, display-area/blank, and sync pulses with programmable timing and polarity, plus line-start and frame-start strobes.
- Feeds font/frame-buffer pixel logic and the DAC interface.

Parameters:
- CLK_DIV, 2, master_clk cycles per pixel (>=1; 1 means pix_ce is constantly high)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CW, 11, width of the coordinate counters

Ports:
- master_clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run/hold control
- pix_ce  out  1  pixel clock-enable, one master_clk cycle wide
- DAC_clk  out  1  pixel-rate clock for the DAC, high for the first ceil(CLK_DIV/2) cycles of each pixel
- xPixel  out  CW  current horizontal count
- yPixel  out  CW  current vertical count
- display_area  out  1  current pixel is within the active region
- blank_n  out  1  equals display_area
- VGA_hSync  out  1  horizontal sync
- VGA_vSync  out  1  vertical sync
- line_start  out  1  one-cycle strobe when xPixel enters 0
- frame_start  out  1  one-cycle strobe when (xPixel, yPixel) enters (0, 0)
- pat_R / pat_G / pat_B  out  8 each  test-pattern colour (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset values:
  - divider counter, xPixel, yPixel = 0
  - display_area, blank_n, line_start, frame_start, pix_ce, DAC_clk = 0
  - VGA_hSync = ~H_POL; VGA_vSync = ~V_POL (both inactive)
  - pat_* = 0
- Divider:
  - Counts 0..CLK_DIV-1 while enable is high.
  - pix_ce = 1 in the cycle the divider equals CLK_DIV-1.
- Counter advance on pix_ce:
  - xPixel increments; at H_TOTAL-1 it wraps to 0 and yPixel increments.
  - yPixel wraps from V_TOTAL-1 to 0 only when xPixel also wraps.
- Registered outputs:
  - All outputs are registered and mutually aligned: display_area, syncs and pat_* reflect the xPixel/yPixel values presented in the same cycle.
  - Derive them from the next-count values; there is no extra pipeline skew.
- display_area = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole of each of those lines.
- line_start and frame_start assert for exactly one master_clk cycle: the cycle in which the wrapped value first appears.
  - At the frame wrap both strobes assert together.
- enable low:
  - Synchronously clears the divider, xPixel and yPixel.
  - Forces display_area/blank_n to 0, syncs inactive, and pix_ce and the strobes to 0.
  - On re-enable the first pix_ce arrives after CLK_DIV cycles.
  - The first frame_start comes at the wrap after a full frame; no strobe is issued at enable.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); restart as after power-up.
- Coordinates never reach or exceed H_TOTAL/V_TOTAL.
- CW must hold max(H_TOTAL, V_TOTAL)-1. An assertion in simulation flags parameter sets that violate this.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - pat_R/G/B output 8 vertical colour bars, bar = x / (H_ACTIVE/8), clamped to 7.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 8'hFF or 8'h00.
  - Outputs are 0 when display_area is 0.
  - Aligned with xPixel/yPixel.
- Undefined: pat_R/G/B are tied to 0 and no bar logic is synthesised.

Test Plan:
- Defaults, reset released, enable=1:
  - pix_ce every 2nd cycle.
  - xPixel wraps 799->0 and yPixel increments.
  - line_start pulses once per 1600 master_clk cycles.
- Defaults, full frame: hsync low for exactly 96 pixels, from x=656 to 751; vsync low on lines 490-491; frame_start period = 800*525*2 = 840000 cycles.
- display_area/blank_n are 1 only for x<640 and y<480; 307200 active pixels counted per frame.
- H_POL=1, V_POL=1, CLK_DIV=1: syncs idle low and pulse high; pix_ce constantly 1; frame period 420000 cycles.
- Drop enable at x=300, y=100 for 10 cycles, then raise it: counters go to 0, syncs inactive, and no frame_start until one full frame later. Assert reset_n low mid-line: outputs reach reset values without a clock edge.
- With VGA_TEST_PATTERN_EN: x=0 gives FF/FF/FF; x=80 gives FF/FF/00; x=639 gives 00/00/00; x=700 gives 0. Without the macro, pat_* are always 0.
